// File: rtl/alu_issue.sv
// ALU operand issue stage: decodes an 8-bit instruction into registered ALU operands.
// Owns the carry/overflow flags and holds carry consumers until producers in flight drain.

package alu_issue_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_LSL = 4'd5;
    localparam logic [3:0] OP_LSR = 4'd6;
    localparam logic [3:0] OP_CSL = 4'd7;
    localparam logic [3:0] OP_CSR = 4'd8;
    localparam logic [3:0] OP_ASR = 4'd9;

    // Data-counter ops: the low two bits carry the channel index and are masked before matching.
    localparam logic [7:0] I_DC_LIMIT  = 8'h30;
    localparam logic [7:0] I_MOVEZ     = 8'h00;
    localparam logic [7:0] I_READZ     = 8'h04;
    localparam logic [7:0] I_WRITEPSTZ = 8'h08;
    localparam logic [7:0] I_WRITEPREZ = 8'h0C;
    localparam logic [7:0] I_RAREADZ   = 8'h10;
    localparam logic [7:0] I_RAWRITEZ  = 8'h14;
    localparam logic [7:0] I_RAREADIZ  = 8'h18;
    localparam logic [7:0] I_RAWRITEIZ = 8'h1C;
    localparam logic [7:0] I_REREADZ   = 8'h20;
    localparam logic [7:0] I_REWRITEZ  = 8'h24;
    localparam logic [7:0] I_REREADIZ  = 8'h28;
    localparam logic [7:0] I_REWRITEIZ = 8'h2C;

    localparam logic [7:0] I_INC    = 8'h30;
    localparam logic [7:0] I_DEC    = 8'h31;
    localparam logic [7:0] I_CARRY  = 8'h32;
    localparam logic [7:0] I_BORROW = 8'h33;
    localparam logic [7:0] I_INV    = 8'h34;
    localparam logic [7:0] I_ADD    = 8'h35;
    localparam logic [7:0] I_SUB    = 8'h36;
    localparam logic [7:0] I_ADDI   = 8'h37;
    localparam logic [7:0] I_SUBI   = 8'h38;
    localparam logic [7:0] I_LSL    = 8'h39;
    localparam logic [7:0] I_LSR    = 8'h3A;
    localparam logic [7:0] I_CSL    = 8'h3B;
    localparam logic [7:0] I_CSR    = 8'h3C;
    localparam logic [7:0] I_ASR    = 8'h3D;
    localparam logic [7:0] I_AND    = 8'h3E;
    localparam logic [7:0] I_OR     = 8'h3F;
    localparam logic [7:0] I_XOR    = 8'h40;
    localparam logic [7:0] I_LSLI   = 8'h41;
    localparam logic [7:0] I_CSLI   = 8'h42;
    localparam logic [7:0] I_ASRI   = 8'h43;
    localparam logic [7:0] I_ANDI   = 8'h44;
    localparam logic [7:0] I_ORI    = 8'h45;
    localparam logic [7:0] I_XORI   = 8'h46;

    localparam logic [7:0] I_BRA      = 8'h50;
    localparam logic [7:0] I_BEQ      = 8'h51;
    localparam logic [7:0] I_BNE      = 8'h52;
    localparam logic [7:0] I_BLES     = 8'h53;
    localparam logic [7:0] I_BLEQ     = 8'h54;
    localparam logic [7:0] I_BLESU    = 8'h55;
    localparam logic [7:0] I_BLEQU    = 8'h56;
    localparam logic [7:0] I_BC       = 8'h57;
    localparam logic [7:0] I_BNC      = 8'h58;
    localparam logic [7:0] I_BO       = 8'h59;
    localparam logic [7:0] I_BNO      = 8'h5A;
    localparam logic [7:0] I_BI       = 8'h5B;
    localparam logic [7:0] I_BNI      = 8'h5C;
    localparam logic [7:0] I_BZ       = 8'h5D;
    localparam logic [7:0] I_BNZ      = 8'h5E;
    localparam logic [7:0] I_WRITEPRI = 8'h5F;
    localparam logic [7:0] I_ILOOP    = 8'h60;
    localparam logic [7:0] I_LOOP     = 8'h61;

endpackage

module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned DC_COUNT   = 4,
    parameter int unsigned FLAG_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [7:0]                           instruction,
    input  logic [WORD_WIDTH-1:0]                imm,
    input  logic [WORD_WIDTH-1:0]                top,
    input  logic [WORD_WIDTH-1:0]                second,
    input  logic [WORD_WIDTH-1:0]                pc,
    input  logic [DC_COUNT-1:0][WORD_WIDTH-1:0] dcs,
    input  logic [DC_COUNT-1:0][WORD_WIDTH-1:0] dc_vals,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [WORD_WIDTH-1:0]                alu_a,
    output logic [WORD_WIDTH-1:0]                alu_b,
    output logic                                 alu_ic,
    output logic [3:0]                           alu_opcode,
    output logic                                 alu_store_flags,
    input  logic                                 flag_valid,
    input  logic                                 flag_carry,
    input  logic                                 flag_overflow,
    output logic                                 carry,
    output logic                                 overflow,
    output logic                                 flag_err
);

    localparam int unsigned DC_IDX_W = (DC_COUNT > 1) ? $clog2(DC_COUNT) : 1;
    localparam int unsigned PEND_W   = $clog2(FLAG_DEPTH + 1);
    localparam int unsigned CNT_W    = PEND_W + 1;

    logic                  out_valid_q, out_valid_d;
    logic [WORD_WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WORD_WIDTH-1:0] alu_b_q, alu_b_d;
    logic                  alu_ic_q, alu_ic_d;
    logic [3:0]            alu_opcode_q, alu_opcode_d;
    logic                  alu_store_flags_q, alu_store_flags_d;
    logic                  carry_q, carry_d;
    logic                  overflow_q, overflow_d;
    logic                  flag_err_q, flag_err_d;
    logic [PEND_W-1:0]     pending_q, pending_d;

    logic [DC_IDX_W-1:0]   dc_idx;
    logic [WORD_WIDTH-1:0] dc_addr, dc_val;
    logic [WORD_WIDTH-1:0] simm8, imm8, simm16, imm16, neg_simm8, ones;
    logic [7:0]            op_key;

    logic [WORD_WIDTH-1:0] dec_a, dec_b;
    logic                  dec_ic, dec_sf, dec_cons;
    logic [3:0]            dec_op;

    logic                  in_hs, out_hs, pend_inc, flag_dec;
    logic                  occ_prod, cons_stall, prod_stall;
    logic [CNT_W-1:0]      flags_owed;

    assign dc_idx    = (DC_COUNT > 1) ? instruction[DC_IDX_W-1:0] : '0;
    assign dc_addr   = dcs[dc_idx];
    assign dc_val    = dc_vals[dc_idx];
    assign simm8     = {{(WORD_WIDTH-8){imm[7]}}, imm[7:0]};
    assign imm8      = {{(WORD_WIDTH-8){1'b0}}, imm[7:0]};
    assign simm16    = {{(WORD_WIDTH-16){imm[15]}}, imm[15:0]};
    assign imm16     = {{(WORD_WIDTH-16){1'b0}}, imm[15:0]};
    assign neg_simm8 = '0 - simm8;
    assign ones      = '1;
    assign op_key    = (instruction < I_DC_LIMIT) ? {instruction[7:2], 2'b00} : instruction;

    // Operand decode of the instruction currently at the input.
    always_comb begin
        dec_a    = '0;
        dec_b    = '0;
        dec_ic   = 1'b0;
        dec_op   = OP_NOP;
        dec_sf   = 1'b0;
        dec_cons = 1'b0;
        case (op_key)
            I_MOVEZ, I_READZ, I_WRITEPSTZ: begin
                dec_a = dc_addr; dec_b = simm8; dec_ic = 1'b1; dec_op = OP_ADD;
            end
            I_WRITEPREZ: begin
                dec_a = dc_addr; dec_b = simm8; dec_op = OP_ADD;
            end
            I_RAREADZ, I_RAWRITEZ: begin
                dec_a = dc_addr; dec_b = top; dec_op = OP_ADD;
            end
            I_RAREADIZ, I_RAWRITEIZ: begin
                dec_a = dc_addr; dec_b = imm8; dec_op = OP_ADD;
            end
            I_REREADZ, I_REWRITEZ: begin
                dec_a = dc_val; dec_b = top; dec_op = OP_ADD;
            end
            I_REREADIZ, I_REWRITEIZ: begin
                dec_a = dc_val; dec_b = imm8; dec_op = OP_ADD;
            end
            I_INC: begin
                dec_b = top; dec_ic = 1'b1; dec_op = OP_ADD; dec_sf = 1'b1;
            end
            I_DEC: begin
                dec_a = ones; dec_b = top; dec_op = OP_ADD; dec_sf = 1'b1;
            end
            I_CARRY: begin
                dec_b = top; dec_ic = carry_q; dec_op = OP_ADD; dec_sf = 1'b1; dec_cons = 1'b1;
            end
            I_BORROW: begin
                dec_a = ones; dec_b = top; dec_ic = carry_q; dec_op = OP_ADD;
                dec_sf = 1'b1; dec_cons = 1'b1;
            end
            I_INV: begin
                dec_a = ones; dec_b = top; dec_op = OP_XOR;
            end
            I_ADD: begin
                dec_a = second; dec_b = top; dec_op = OP_ADD; dec_sf = 1'b1;
            end
            I_SUB: begin
                dec_a = second; dec_b = ~top; dec_ic = 1'b1; dec_op = OP_ADD; dec_sf = 1'b1;
            end
            I_ADDI: begin
                dec_a = imm; dec_b = top; dec_op = OP_ADD; dec_sf = 1'b1;
            end
            I_SUBI: begin
                dec_a = imm; dec_b = ~top; dec_ic = 1'b1; dec_op = OP_ADD; dec_sf = 1'b1;
            end
            I_LSL: begin dec_a = second; dec_b = top; dec_op = OP_LSL; end
            I_LSR: begin dec_a = second; dec_b = top; dec_op = OP_LSR; end
            I_CSL: begin dec_a = second; dec_b = top; dec_op = OP_CSL; end
            I_CSR: begin dec_a = second; dec_b = top; dec_op = OP_CSR; end
            I_ASR: begin dec_a = second; dec_b = top; dec_op = OP_ASR; end
            I_AND: begin dec_a = second; dec_b = top; dec_op = OP_AND; end
            I_OR:  begin dec_a = second; dec_b = top; dec_op = OP_OR;  end
            I_XOR: begin dec_a = second; dec_b = top; dec_op = OP_XOR; end
            // Negative shift immediates turn a left shift into a right shift by the magnitude.
            I_LSLI: begin
                dec_a = top;
                if (imm[7]) begin
                    dec_b = neg_simm8; dec_op = OP_LSR;
                end else begin
                    dec_b = imm8; dec_op = OP_LSL;
                end
            end
            I_CSLI: begin dec_a = top; dec_b = simm8; dec_op = OP_CSL; end
            I_ASRI: begin dec_a = top; dec_b = imm8;  dec_op = OP_ASR; end
            I_ANDI: begin dec_a = top; dec_b = imm;   dec_op = OP_AND; end
            I_ORI:  begin dec_a = top; dec_b = imm;   dec_op = OP_OR;  end
            I_XORI: begin dec_a = top; dec_b = imm;   dec_op = OP_XOR; end
            I_BRA, I_BEQ, I_BNE, I_BLES, I_BLEQ, I_BLESU, I_BLEQU, I_BC, I_BNC,
            I_BO, I_BNO, I_BI, I_BNI, I_BZ, I_BNZ, I_WRITEPRI: begin
                dec_a = pc; dec_b = simm16; dec_op = OP_ADD;
            end
            I_ILOOP, I_LOOP: begin
                dec_a = pc; dec_b = imm16; dec_op = OP_ADD;
            end
            default: ;
        endcase
    end

    // A producer still in the output register counts as owed flags for both stall checks.
    assign occ_prod   = out_valid_q & alu_store_flags_q;
    assign flags_owed = CNT_W'(pending_q) + CNT_W'(occ_prod);
    assign cons_stall = dec_cons & (flags_owed != '0);
    assign prod_stall = dec_sf & (flags_owed >= CNT_W'(FLAG_DEPTH));
    assign in_ready   = (~out_valid_q | out_ready) & ~(cons_stall | prod_stall);

    assign in_hs    = in_valid & in_ready;
    assign out_hs   = out_valid_q & out_ready;
    assign pend_inc = out_hs & alu_store_flags_q;
    assign flag_dec = flag_valid & (pending_q != '0);

    always_comb begin
        out_valid_d       = out_valid_q;
        alu_a_d           = alu_a_q;
        alu_b_d           = alu_b_q;
        alu_ic_d          = alu_ic_q;
        alu_opcode_d      = alu_opcode_q;
        alu_store_flags_d = alu_store_flags_q;
        carry_d           = carry_q;
        overflow_d        = overflow_q;
        pending_d         = pending_q;
        flag_err_d        = flag_valid & (pending_q == '0);

        if (in_hs) begin
            out_valid_d       = 1'b1;
            alu_a_d           = dec_a;
            alu_b_d           = dec_b;
            alu_ic_d          = dec_ic;
            alu_opcode_d      = dec_op;
            alu_store_flags_d = dec_sf;
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end

        case ({pend_inc, flag_dec})
            2'b10:   pending_d = pending_q + PEND_W'(1);
            2'b01:   pending_d = pending_q - PEND_W'(1);
            default: pending_d = pending_q;
        endcase

        if (flag_dec) begin
            carry_d    = flag_carry;
            overflow_d = flag_overflow;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q       <= 1'b0;
            alu_a_q           <= '0;
            alu_b_q           <= '0;
            alu_ic_q          <= 1'b0;
            alu_opcode_q      <= OP_NOP;
            alu_store_flags_q <= 1'b0;
            carry_q           <= 1'b0;
            overflow_q        <= 1'b0;
            flag_err_q        <= 1'b0;
            pending_q         <= '0;
        end else begin
            out_valid_q       <= out_valid_d;
            alu_a_q           <= alu_a_d;
            alu_b_q           <= alu_b_d;
            alu_ic_q          <= alu_ic_d;
            alu_opcode_q      <= alu_opcode_d;
            alu_store_flags_q <= alu_store_flags_d;
            carry_q           <= carry_d;
            overflow_q        <= overflow_d;
            flag_err_q        <= flag_err_d;
            pending_q         <= pending_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign alu_a           = alu_a_q;
    assign alu_b           = alu_b_q;
    assign alu_ic          = alu_ic_q;
    assign alu_opcode      = alu_opcode_q;
    assign alu_store_flags = alu_store_flags_q;
    assign carry           = carry_q;
    assign overflow        = overflow_q;
    assign flag_err        = flag_err_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios then randomized traffic,
// all compared against a transaction-level reference model of the issue stage.

module tb_alu_issue;
    import alu_issue_pkg::*;

    localparam int unsigned W   = 32;
    localparam int unsigned DCN = 2;
    localparam int unsigned FD  = 2;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ic;
        logic [3:0]   op;
        logic         sf;
        logic         cons;
    } ref_t;

    logic                    clk, reset, in_valid, in_ready, out_valid, out_ready;
    logic [7:0]              instruction;
    logic [W-1:0]            imm, top, second, pc, alu_a, alu_b;
    logic [DCN-1:0][W-1:0]   dcs, dc_vals;
    logic                    alu_ic, alu_store_flags;
    logic [3:0]              alu_opcode;
    logic                    flag_valid, flag_carry, flag_overflow, carry, overflow, flag_err;

    alu_issue #(.WORD_WIDTH(W), .DC_COUNT(DCN), .FLAG_DEPTH(FD)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .imm(imm), .top(top), .second(second), .pc(pc),
        .dcs(dcs), .dc_vals(dc_vals), .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ic(alu_ic), .alu_opcode(alu_opcode),
        .alu_store_flags(alu_store_flags), .flag_valid(flag_valid),
        .flag_carry(flag_carry), .flag_overflow(flag_overflow),
        .carry(carry), .overflow(overflow), .flag_err(flag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: contents of the output stage, architectural flags, flags owed by the ALU.
    logic         m_valid, m_ic, m_sf, m_carry, m_ovf, m_err;
    logic [W-1:0] m_a, m_b;
    logic [3:0]   m_op;
    int           m_pend;
    logic         last_rdy;
    logic [W-1:0] held_a;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic ref_t ref_op(input logic [7:0] ins, input logic [W-1:0] i_imm,
                                    input logic [W-1:0] i_top, input logic [W-1:0] i_sec,
                                    input logic [W-1:0] i_pc, input logic [W-1:0] i_dca,
                                    input logic [W-1:0] i_dcv, input logic cy);
        ref_t r;
        logic [W-1:0] s8, z8, s16, z16, ones;
        logic [3:0]   grp;
        r = '0;
        r.op = OP_NOP;
        s8   = W'(int'($signed(i_imm[7:0])));
        z8   = W'(i_imm[7:0]);
        s16  = W'(int'($signed(i_imm[15:0])));
        z16  = W'(i_imm[15:0]);
        ones = '1;
        if (ins < 8'h30) begin
            // twelve 4-wide groups: 0-3 address+simm8, 4-7 address, 8-11 value; odd pairs use imm8
            grp  = ins[5:2];
            r.op = OP_ADD;
            r.a  = (grp < 4'd8) ? i_dca : i_dcv;
            if (grp < 4'd4) begin
                r.b  = s8;
                r.ic = (grp != 4'd3);
            end else begin
                r.b = grp[1] ? z8 : i_top;
            end
        end else if (ins >= I_BRA && ins <= I_WRITEPRI) begin
            r.a = i_pc; r.b = s16; r.op = OP_ADD;
        end else begin
            case (ins)
                I_ILOOP, I_LOOP: begin r.a = i_pc; r.b = z16; r.op = OP_ADD; end
                I_INC:    begin r.b = i_top; r.ic = 1'b1; r.op = OP_ADD; r.sf = 1'b1; end
                I_DEC:    begin r.a = ones; r.b = i_top; r.op = OP_ADD; r.sf = 1'b1; end
                I_CARRY:  begin r.b = i_top; r.ic = cy; r.op = OP_ADD; r.sf = 1'b1; r.cons = 1'b1; end
                I_BORROW: begin r.a = ones; r.b = i_top; r.ic = cy; r.op = OP_ADD; r.sf = 1'b1; r.cons = 1'b1; end
                I_INV:    begin r.a = ones; r.b = i_top; r.op = OP_XOR; end
                I_ADD, I_SUB, I_ADDI, I_SUBI: begin
                    r.a  = (ins == I_ADD || ins == I_SUB) ? i_sec : i_imm;
                    r.ic = (ins == I_SUB || ins == I_SUBI);
                    r.b  = r.ic ? ~i_top : i_top;
                    r.op = OP_ADD;
                    r.sf = 1'b1;
                end
                I_LSL: begin r.a = i_sec; r.b = i_top; r.op = OP_LSL; end
                I_LSR: begin r.a = i_sec; r.b = i_top; r.op = OP_LSR; end
                I_CSL: begin r.a = i_sec; r.b = i_top; r.op = OP_CSL; end
                I_CSR: begin r.a = i_sec; r.b = i_top; r.op = OP_CSR; end
                I_ASR: begin r.a = i_sec; r.b = i_top; r.op = OP_ASR; end
                I_AND: begin r.a = i_sec; r.b = i_top; r.op = OP_AND; end
                I_OR:  begin r.a = i_sec; r.b = i_top; r.op = OP_OR;  end
                I_XOR: begin r.a = i_sec; r.b = i_top; r.op = OP_XOR; end
                I_LSLI: begin
                    r.a = i_top;
                    if (i_imm[7]) begin r.b = W'(-int'($signed(i_imm[7:0]))); r.op = OP_LSR; end
                    else begin r.b = z8; r.op = OP_LSL; end
                end
                I_CSLI: begin r.a = i_top; r.b = s8;    r.op = OP_CSL; end
                I_ASRI: begin r.a = i_top; r.b = z8;    r.op = OP_ASR; end
                I_ANDI: begin r.a = i_top; r.b = i_imm; r.op = OP_AND; end
                I_ORI:  begin r.a = i_top; r.b = i_imm; r.op = OP_OR;  end
                I_XORI: begin r.a = i_top; r.b = i_imm; r.op = OP_XOR; end
                default: ;
            endcase
        end
        return r;
    endfunction

    task automatic m_reset();
        m_valid = 1'b0; m_a = '0; m_b = '0; m_ic = 1'b0; m_op = OP_NOP; m_sf = 1'b0;
        m_carry = 1'b0; m_ovf = 1'b0; m_err = 1'b0; m_pend = 0;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_valid"}, W'(out_valid), '0);
        check({tag, "_a"}, alu_a, '0);
        check({tag, "_b"}, alu_b, '0);
        check({tag, "_ic"}, W'(alu_ic), '0);
        check({tag, "_op"}, W'(alu_opcode), W'(OP_NOP));
        check({tag, "_sf"}, W'(alu_store_flags), '0);
        check({tag, "_carry"}, W'(carry), '0);
        check({tag, "_ovf"}, W'(overflow), '0);
        check({tag, "_err"}, W'(flag_err), '0);
    endtask

    // One clock: called at posedge+1, drives inputs, checks in_ready at negedge, checks outputs after the edge.
    task automatic step(input logic iv, input logic [7:0] ins, input logic ordy,
                        input logic fv, input logic fc, input logic fo);
        ref_t r;
        logic exp_rdy, acc, ohs;
        logic ch;
        int   owed;
        in_valid = iv; instruction = ins; out_ready = ordy;
        flag_valid = fv; flag_carry = fc; flag_overflow = fo;
        ch   = ins[0];
        r    = ref_op(ins, imm, top, second, pc, dcs[ch], dc_vals[ch], m_carry);
        owed = m_pend + ((m_valid && m_sf) ? 1 : 0);
        exp_rdy = (!m_valid || ordy) && !((r.cons && owed != 0) || (r.sf && owed >= int'(FD)));
        #4;
        check("in_ready", W'(in_ready), W'(exp_rdy));
        last_rdy = in_ready;
        acc = iv && exp_rdy;
        ohs = m_valid && ordy;
        @(posedge clk);
        #1;
        m_err = fv && (m_pend == 0);
        if (fv && m_pend > 0) begin
            m_carry = fc; m_ovf = fo; m_pend--;
        end
        if (ohs && m_sf) m_pend++;
        if (acc) begin
            m_valid = 1'b1; m_a = r.a; m_b = r.b; m_ic = r.ic; m_op = r.op; m_sf = r.sf;
        end else if (ohs) begin
            m_valid = 1'b0;
        end
        check("out_valid", W'(out_valid), W'(m_valid));
        if (m_valid) begin
            check("alu_a", alu_a, m_a);
            check("alu_b", alu_b, m_b);
            check("alu_ic", W'(alu_ic), W'(m_ic));
            check("alu_opcode", W'(alu_opcode), W'(m_op));
            check("store_flags", W'(alu_store_flags), W'(m_sf));
        end
        check("carry", W'(carry), W'(m_carry));
        check("overflow", W'(overflow), W'(m_ovf));
        check("flag_err", W'(flag_err), W'(m_err));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; instruction = '0; out_ready = 1'b0;
        imm = '0; top = '0; second = '0; pc = '0; dcs = '0; dc_vals = '0;
        flag_valid = 1'b0; flag_carry = 1'b0; flag_overflow = 1'b0;
        last_rdy = 1'b0; held_a = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outs("rst");
        reset = 1'b0;

        // First issue: one-cycle latency, producer marked.
        second = 32'd5; top = 32'hFFFF_FFFF;
        step(1'b1, I_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        check("add_a", alu_a, 32'd5);
        check("add_b", alu_b, 32'hFFFF_FFFF);
        check("add_op", W'(alu_opcode), W'(OP_ADD));
        check("add_sf", W'(alu_store_flags), W'(1'b1));

        // Carry consumer waits for the ADD flags, then samples the returned carry.
        top = 32'd7;
        step(1'b1, I_CARRY, 1'b1, 1'b0, 1'b0, 1'b0);
        check("carry_stall0", W'(last_rdy), '0);
        step(1'b1, I_CARRY, 1'b1, 1'b1, 1'b1, 1'b0);
        check("carry_stall1", W'(last_rdy), '0);
        step(1'b1, I_CARRY, 1'b1, 1'b0, 1'b0, 1'b0);
        check("carry_a", alu_a, '0);
        check("carry_b", alu_b, 32'd7);
        check("carry_ic", W'(alu_ic), W'(1'b1));

        top = 32'h1234_5678; imm = 32'h0000_00FD;
        step(1'b1, I_LSLI, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lsli_neg_a", alu_a, 32'h1234_5678);
        check("lsli_neg_b", alu_b, 32'd3);
        check("lsli_neg_op", W'(alu_opcode), W'(OP_LSR));
        imm = 32'h0000_0005;
        step(1'b1, I_LSLI, 1'b1, 1'b1, 1'b0, 1'b0);
        check("lsli_pos_b", alu_b, 32'd5);
        check("lsli_pos_op", W'(alu_opcode), W'(OP_LSL));

        dc_vals[0] = 32'h0BAD_0000; dc_vals[1] = 32'hCAFE_0001; imm = 32'h0000_01FF;
        step(1'b1, I_REREADIZ | 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rereadiz_a", alu_a, 32'hCAFE_0001);
        check("rereadiz_b", alu_b, 32'h0000_00FF);

        // Flag depth of two: third producer waits for a return.
        second = 32'd1; top = 32'd2;
        step(1'b1, I_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, I_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, I_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        check("depth_stall0", W'(last_rdy), '0);
        step(1'b1, I_ADD, 1'b1, 1'b1, 1'b0, 1'b0);
        check("depth_stall1", W'(last_rdy), '0);
        second = 32'hA5A5_0003;
        step(1'b1, I_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        check("depth_accept", W'(last_rdy), W'(1'b1));

        // Back-pressure: outputs hold while out_ready is low.
        repeat (3) step(1'b1, I_INV, 1'b0, 1'b0, 1'b0, 1'b0);
        check("hold_a", alu_a, 32'hA5A5_0003);
        check("hold_valid", W'(out_valid), W'(1'b1));
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);

        // Unexpected flag return: error pulse, flags untouched.
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
        check("err_pulse", W'(flag_err), W'(1'b1));
        check("err_carry", W'(carry), W'(1'b1));
        check("err_ovf", W'(overflow), '0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        check("err_clear", W'(flag_err), '0);

        // Reset in the middle of a consumer stall.
        step(1'b1, I_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, I_BORROW, 1'b1, 1'b0, 1'b0, 1'b0);
        check("pre_rst_stall", W'(last_rdy), '0);
        reset = 1'b1; in_valid = 1'b0; flag_valid = 1'b0;
        #1;
        check_reset_outs("mid_rst");
        m_reset();
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
        check("late_flag_err", W'(flag_err), W'(1'b1));

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] ins;
            logic       fv;
            imm = $urandom; top = $urandom; second = $urandom; pc = $urandom;
            dcs[0] = $urandom; dcs[1] = $urandom; dc_vals[0] = $urandom; dc_vals[1] = $urandom;
            ins = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8'h61));
            fv  = (m_pend > 0 && $urandom_range(0, 2) == 0) || ($urandom_range(0, 63) == 0);
            step($urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) != 0,
                 fv, 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
